// File: rtl/interval_timer.sv
// Programmable interval timer: three reloadable interval registers and a down-counter
// that emits a one-cycle Expired pulse when the selected interval has elapsed.
module interval_timer #(
  parameter logic [3:0] T_BASE_DEF = 4'd6,
  parameter logic [3:0] T_EXT_DEF  = 4'd3,
  parameter logic [3:0] T_YEL_DEF  = 4'd2
) (
  input  logic       clock,
  input  logic       Reset_Sync,
  input  logic       Prog_Sync,
  input  logic [1:0] Selector,
  input  logic [3:0] Time_Value,
  input  logic       One_Hz_Enable,
  input  logic       Start_Timer,
  input  logic [1:0] Interval,
  output logic       Expired,
  output logic [3:0] Time_Left
);

  typedef enum logic [1:0] {
    StIdle,
    StRunning,
    StExpire
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] t_base_q, t_base_d;
  logic [3:0] t_ext_q, t_ext_d;
  logic [3:0] t_yel_q, t_yel_d;
  logic [3:0] load_value;
  logic [3:0] prog_value;

  // Loads read the registered values, so a same-cycle write only affects later loads.
  always_comb begin
    load_value = t_base_q;
    case (Interval)
      2'd1:    load_value = t_ext_q;
      2'd2:    load_value = t_yel_q;
      default: load_value = t_base_q;
    endcase
  end

  // Zero is clamped to the 1 s minimum interval.
  assign prog_value = (Time_Value == 4'd0) ? 4'd1 : Time_Value;

  always_comb begin
    t_base_d = t_base_q;
    t_ext_d  = t_ext_q;
    t_yel_d  = t_yel_q;
    if (Prog_Sync) begin
      case (Selector)
        2'b00:   t_base_d = prog_value;
        2'b01:   t_ext_d  = prog_value;
        2'b10:   t_yel_d  = prog_value;
        default: ;
      endcase
    end
  end

  // A start request takes priority over any tick in the same cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (Start_Timer) begin
      count_d = load_value;
      state_d = StRunning;
    end else begin
      case (state_q)
        StRunning: begin
          if (One_Hz_Enable) begin
            if (count_q <= 4'd1) begin
              count_d = 4'd0;
              state_d = StExpire;
            end else begin
              count_d = count_q - 4'd1;
            end
          end
        end
        StExpire: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      state_q  <= StIdle;
      count_q  <= 4'd0;
      t_base_q <= T_BASE_DEF;
      t_ext_q  <= T_EXT_DEF;
      t_yel_q  <= T_YEL_DEF;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      t_base_q <= t_base_d;
      t_ext_q  <= t_ext_d;
      t_yel_q  <= t_yel_d;
    end
  end

  assign Expired   = (state_q == StExpire);
  assign Time_Left = count_q;

endmodule

// File: tb/tb_interval_timer.sv
// Randomized scoreboard bench for interval_timer: an abstract model predicts Time_Left
// every cycle and the cycle of each Expired pulse.
module tb_interval_timer;

  logic       clock = 1'b0;
  logic       Reset_Sync = 1'b1;
  logic       Prog_Sync = 1'b0;
  logic [1:0] Selector = 2'd3;
  logic [3:0] Time_Value = 4'd0;
  logic       One_Hz_Enable = 1'b0;
  logic       Start_Timer = 1'b0;
  logic [1:0] Interval = 2'd0;
  logic       Expired;
  logic [3:0] Time_Left;

  interval_timer dut (
    .clock        (clock),
    .Reset_Sync   (Reset_Sync),
    .Prog_Sync    (Prog_Sync),
    .Selector     (Selector),
    .Time_Value   (Time_Value),
    .One_Hz_Enable(One_Hz_Enable),
    .Start_Timer  (Start_Timer),
    .Interval     (Interval),
    .Expired      (Expired),
    .Time_Left    (Time_Left)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_q[$];   // cycle numbers in which an Expired pulse is due

  // Abstract model: seconds remaining, whether a count is live, and the three intervals.
  int m_regs[3];
  int m_rem;
  bit m_run;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: consumes expected pulses and flags missing or extra ones.
  always @(negedge clock) begin
    if (!Reset_Sync) begin
      if (exp_q.size() != 0 && exp_q[0] < cyc) begin
        total++;
        bad++;
        $display("FAIL expired_missing: got 0 expected 1 (due cycle %0d)", exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (Expired) begin
        if (exp_q.size() != 0 && exp_q[0] == cyc) begin
          total++;
          void'(exp_q.pop_front());
        end else begin
          total++;
          bad++;
          $display("FAIL expired_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end
      end
    end
  end

  task automatic model_reset();
    m_regs[0] = 6;
    m_regs[1] = 3;
    m_regs[2] = 2;
    m_rem = 0;
    m_run = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    Reset_Sync = 1'b1;
    #1;
    check("reset_time_left", int'(Time_Left), 0);
    check("reset_expired", int'(Expired), 0);
    model_reset();
    Start_Timer = 0;
    One_Hz_Enable = 0;
    Prog_Sync = 0;
    @(negedge clock);
    Reset_Sync = 1'b0;
  endtask

  // One clock of stimulus: check the previous edge's result, drive, then advance the model.
  task automatic step(input bit st, input int iv, input bit tk, input bit pg, input int sl,
                      input int tv);
    int idx;
    @(negedge clock);
    check("time_left", int'(Time_Left), m_rem);
    Start_Timer   = st;
    Interval      = 2'(iv);
    One_Hz_Enable = tk;
    Prog_Sync     = pg;
    Selector      = 2'(sl);
    Time_Value    = 4'(tv);
    idx = (iv == 3) ? 0 : iv;
    if (st) begin
      m_rem = m_regs[idx];
      m_run = 1;
    end else if (m_run && tk) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_run = 0;
        exp_q.push_back(cyc + 1);
      end
    end
    if (pg && sl != 3) m_regs[sl] = (tv == 0) ? 1 : tv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 3, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, 3, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    do_reset();

    ticks(3);                    // ticks while idle
    step(1, 0, 0, 0, 3, 0);      // base run of 6
    ticks(6);
    idle(2);

    step(0, 0, 0, 1, 1, 9);      // program ext=9
    step(1, 1, 0, 0, 3, 0);
    ticks(9);
    idle(2);
    step(0, 0, 0, 1, 1, 0);      // ext=0 stores 1
    step(1, 1, 0, 0, 3, 0);
    ticks(1);
    idle(2);

    step(1, 2, 1, 0, 3, 0);      // start with coincident tick
    ticks(2);
    idle(2);
    step(0, 0, 0, 1, 3, 7);      // selector 11 writes nothing
    step(1, 3, 0, 0, 3, 0);      // interval 3 uses base
    ticks(3);
    step(0, 0, 0, 1, 1, 3);      // program ext=3 mid-count
    step(1, 1, 0, 0, 3, 0);      // restart at 3 remaining
    ticks(3);
    step(1, 0, 0, 1, 0, 5);      // start in EXPIRE with same-cycle base write
    ticks(1);
    step(1, 2, 0, 0, 3, 0);
    ticks(2);
    idle(2);

    step(1, 0, 0, 0, 3, 0);
    for (int i = 0; i < 16 && m_rem != 4; i++) ticks(1);
    do_reset();                  // abort mid-count
    step(1, 0, 0, 0, 3, 0);
    step(1, 1, 0, 0, 3, 0);
    step(1, 2, 0, 0, 3, 0);
    idle(3);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 29) == 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    end
    idle(60);
    check("pending_expiries", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 The block SHALL have one clock domain; reset is asynchronous and active-high.
REQ-002 Parameter: T_BASE_DEF, 4'd6, power-up/reset value of the base interval in seconds.
REQ-003 Parameter: T_EXT_DEF, 4'd3, power-up/reset value of the extended interval in seconds.
REQ-004 Parameter: T_YEL_DEF, 4'd2, power-up/reset value of the yellow interval in seconds.
REQ-005 Port: clock  input  1  system clock; all state changes on its rising edge.
REQ-006 Port: Reset_Sync  input  1  asynchronous active-high reset.
REQ-007 Port: Prog_Sync  input  1  level; while high, writes Time_Value into the register chosen by Selector every clock.
REQ-008 Port: Selector  input  2  programming target: 00 base, 01 extended, 10 yellow, 11 none.
REQ-009 Port: Time_Value  input  4  programmed interval in seconds.
REQ-010 Port: One_Hz_Enable  input  1  single-cycle tick, one per second.
REQ-011 Port: Start_Timer  input  1  single-cycle request to (re)start timing.
REQ-012 Port: Interval  input  2  interval select for the start: 0 base, 1 extended, 2 yellow, 3 treated as base.
REQ-013 Port: Expired  output  1  single-cycle pulse at end of timed interval.
REQ-014 Port: Time_Left  output  4  current down-counter value, for display.

Function
REQ-015 The block SHALL hold three 4-bit interval registers: t_base, t_ext, t_yel.
REQ-016 A Prog_Sync write of Time_Value 0 SHALL store 1 (minimum interval is 1 s); Selector 11 SHALL change no register.
REQ-017 The block SHALL implement a three-state machine: IDLE, RUNNING, EXPIRE.
REQ-018 In any state, Start_Timer high SHALL load counter with the selected interval register and enter RUNNING on the next edge.
REQ-019 On simultaneous Prog_Sync and Start_Timer, the load SHALL use the pre-write register value.
REQ-020 On simultaneous Start_Timer and One_Hz_Enable, the load SHALL win; the tick is discarded.
REQ-021 In RUNNING, each One_Hz_Enable SHALL decrement the counter by 1.
REQ-022 In RUNNING, One_Hz_Enable with counter equal to 1 SHALL set counter to 0 and enter EXPIRE.
REQ-023 Expired SHALL be high exactly when state is EXPIRE; EXPIRE SHALL last one clock, then IDLE (or RUNNING if Start_Timer is high that cycle).
REQ-024 An interval of N SHALL produce Expired in the cycle after the Nth One_Hz_Enable following the load.
REQ-025 In IDLE and EXPIRE, One_Hz_Enable SHALL be ignored and the counter SHALL hold.
REQ-026 Prog_Sync SHALL NOT disturb a running count; the new value applies only at the next load.
REQ-027 The counter SHALL never wrap below 0.
REQ-028 Time_Left SHALL equal the counter register at all times.

Reset
REQ-029 Reset_Sync high SHALL immediately force: state IDLE, counter 0, Expired 0, Time_Left 0, t_base T_BASE_DEF, t_ext T_EXT_DEF, t_yel T_YEL_DEF.
REQ-030 Reset asserted mid-count SHALL abort the interval with no Expired pulse.
REQ-031 After reset release, the block SHALL stay IDLE until Start_Timer.

Verification
REQ-032 Reset; Start_Timer with Interval=0; 6 ticks -> Time_Left 6,5,4,3,2,1,0; Expired one cycle after 6th tick, then IDLE.
REQ-033 Prog_Sync, Selector=01, Time_Value=9; Start_Timer with Interval=1 -> Expired after 9th tick; Time_Value=0 write -> 1-tick interval.
REQ-034 Start_Timer with Interval=2 coincident with tick -> loads 2, tick ignored; Expired after two later ticks; Interval=3 -> loads t_base.
REQ-035 Restart: Start_Timer at Time_Left=3 with Interval=1 -> reload 3, no Expired from first run; Start_Timer during EXPIRE -> RUNNING next cycle.
REQ-036 Reset_Sync mid-count (Time_Left=4) -> Time_Left 0 immediately, no Expired, registers back to 6/3/2.
REQ-037 Ticks in IDLE -> Time_Left constant, Expired stays 0.
